axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI slave that maps one address region onto a single-port synchronous SRAM.
// One transaction is in flight at a time. Reads cost two cycles per beat.
module axi_sram_slave #(
  parameter int                ID_W        = 8,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_AW      = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0001_0000
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // AW
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  // W
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // B
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // AR
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  // R
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  // SRAM
  output logic                CS,
  output logic                OE,
  output logic [DATA_W/8-1:0] WEB,
  output logic [MEM_AW-1:0]   A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int BYTE_OFF = $clog2(STRB_W);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_DATA = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_MEM  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [2:0]        state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hold_q, hold_d;

  logic              sel_aw;
  logic [ADDR_W-1:0] req_addr, req_off;
  logic [ID_W-1:0]   req_id;
  logic [3:0]        req_len;
  logic [2:0]        req_size;
  logic [1:0]        req_burst, req_err;
  logic              req_hit, beat_last;
  logic [DATA_W-1:0] rdata_live;

  // Tie goes to the channel type that was not granted last.
  assign sel_aw    = AWVALID & (~ARVALID | ~last_wr_q);
  assign req_addr  = sel_aw ? AWADDR  : ARADDR;
  assign req_id    = sel_aw ? AWID    : ARID;
  assign req_len   = sel_aw ? AWLEN   : ARLEN;
  assign req_size  = sel_aw ? AWSIZE  : ARSIZE;
  assign req_burst = sel_aw ? AWBURST : ARBURST;
  assign req_off   = req_addr - BASE_ADDR;
  // Offset check avoids overflow of BASE_ADDR + REGION_SIZE.
  assign req_hit   = (req_addr >= BASE_ADDR) && (req_off < REGION_SIZE);
  assign req_err   = !req_hit ? RESP_DECERR :
                     ((req_burst == 2'b11) || (req_size != 3'(BYTE_OFF))) ? RESP_SLVERR :
                     RESP_OKAY;
  assign beat_last = (cnt_q == len_q);
  // DO is live only in the first RD_DATA cycle; after that the captured copy is held.
  assign rdata_live = hold_q ? rdata_q : ((err_q != RESP_OKAY) ? '0 : DO);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    hold_d    = hold_q;
    AWREADY   = 1'b0;
    ARREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BID       = '0;
    BRESP     = '0;
    RVALID    = 1'b0;
    RID       = '0;
    RRESP     = '0;
    RLAST     = 1'b0;
    RDATA     = rdata_q;
    CS        = 1'b0;
    OE        = 1'b0;
    WEB       = '1;
    A         = addr_q;
    DI        = '0;
    case (state_q)
      S_IDLE: begin
        AWREADY = sel_aw;
        ARREADY = ARVALID & ~sel_aw;
        if (AWVALID | ARVALID) begin
          id_d    = req_id;
          addr_d  = req_off[BYTE_OFF +: MEM_AW];
          len_d   = req_len;
          burst_d = req_burst;
          cnt_d   = '0;
          err_d   = req_err;
          bresp_d = RESP_OKAY;
          state_d = sel_aw ? S_WR_DATA : S_RD_MEM;
        end
      end
      S_WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          CS  = 1'b1;
          WEB = (err_q != RESP_OKAY) ? '1 : ~WSTRB;
          DI  = WDATA;
          if (WLAST | beat_last) begin
            state_d = S_WR_RESP;
            bresp_d = (err_q != RESP_OKAY)  ? err_q :
                      (WLAST & beat_last)   ? RESP_OKAY : RESP_SLVERR;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (burst_q != 2'b00) addr_d = addr_q + MEM_AW'(1);
          end
        end
      end
      S_WR_RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = bresp_q;
        if (BREADY) begin
          state_d   = S_IDLE;
          last_wr_d = 1'b1;
        end
      end
      S_RD_MEM: begin
        CS      = (err_q == RESP_OKAY);
        OE      = (err_q == RESP_OKAY);
        hold_d  = 1'b0;
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        RVALID  = 1'b1;
        RID     = id_q;
        RRESP   = err_q;
        RLAST   = beat_last;
        RDATA   = rdata_live;
        rdata_d = rdata_live;
        hold_d  = 1'b1;
        if (RREADY) begin
          if (beat_last) begin
            state_d   = S_IDLE;
            last_wr_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            if (burst_q != 2'b00) addr_d = addr_q + MEM_AW'(1);
            state_d = S_RD_MEM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing handshakes or touches the SRAM in a reset cycle.
    if (ARESET) begin
      AWREADY = 1'b0;
      ARREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      RVALID  = 1'b0;
      CS      = 1'b0;
      OE      = 1'b0;
      WEB     = '1;
      DI      = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      bresp_q   <= '0;
      rdata_q   <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural synchronous SRAM attached.
module tb_axi_sram_slave;
  localparam int MEM_AW = 14;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, DI, DO;
  logic [3:0]  AWLEN, ARLEN, WSTRB, WEB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CS, OE;
  logic [13:0] A;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int cs_cnt = 0;
  logic mem_clr;
  logic [31:0] mem [0:(1<<MEM_AW)-1];

  always #5 ACLK = ~ACLK;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  // SRAM model: byte-masked write, read data appears after the access edge.
  always @(posedge ACLK) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<MEM_AW); i++) mem[i] <= '0;
    end else if (CS && !OE) begin
      for (int b = 0; b < 4; b++) if (!WEB[b]) mem[A][b*8 +: 8] <= DI[b*8 +: 8];
    end
    if (CS && OE) DO <= mem[A];
    if (CS) cs_cnt <= cs_cnt + 1;
    if (CS && !OE && WEB != 4'hF) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, output bit ok);
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (AWREADY) ok = 1'b1;
      else @(negedge ACLK);
    end
    @(posedge ACLK); #1 AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, output bit ok);
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (ARREADY) ok = 1'b1;
      else @(negedge ACLK);
    end
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input bit last,
                        output bit ok, output logic [13:0] a, output logic [3:0] web,
                        output logic cs, output logic [31:0] di);
    @(negedge ACLK);
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    ok = 1'b0; a = '0; web = '0; cs = 1'b0; di = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (WREADY) begin
        ok = 1'b1; a = A; web = WEB; cs = CS; di = DI;
      end else @(negedge ACLK);
    end
    @(posedge ACLK); #1 WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_recv(output bit ok, output logic [7:0] id, output logic [1:0] resp);
    @(negedge ACLK);
    BREADY = 1'b1; ok = 1'b0; id = '0; resp = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (BVALID) begin
        ok = 1'b1; id = BID; resp = BRESP;
      end else @(negedge ACLK);
    end
    @(posedge ACLK); #1 BREADY = 1'b0;
  endtask

  task automatic r_recv(input int stall, output bit ok, output logic [31:0] data,
                        output logic [1:0] resp, output bit last, output logic [7:0] id,
                        output bit stable);
    @(negedge ACLK);
    RREADY = 1'b0; ok = 1'b0; data = '0; resp = '0; last = 1'b0; id = '0; stable = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (RVALID) begin
        ok = 1'b1; data = RDATA; resp = RRESP; last = RLAST; id = RID;
      end else @(negedge ACLK);
    end
    if (ok) begin
      repeat (stall) begin
        @(negedge ACLK); #1;
        if (RDATA !== data || !RVALID || RLAST !== last) stable = 1'b0;
      end
    end
    RREADY = 1'b1;
    @(posedge ACLK); #1 RREADY = 1'b0;
  endtask

  task automatic test_reset;
    ARESET = 1'b1; mem_clr = 1'b1;
    AWVALID = 1'b1; ARVALID = 1'b1; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if ({AWREADY, ARREADY, WREADY} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b expected 000", {AWREADY, ARREADY, WREADY});
    end
    checks++;
    if ({BVALID, RVALID, RLAST, CS, OE} !== 5'b0) begin
      errors++; $display("FAIL reset_valid_sram: got %b expected 00000", {BVALID, RVALID, RLAST, CS, OE});
    end
    checks++;
    if (WEB !== 4'hF || DI !== 32'h0) begin
      errors++; $display("FAIL reset_web_di: got %h/%h expected f/00000000", WEB, DI);
    end
    checks++;
    if (RDATA !== 32'h0 || {BRESP, RRESP, BID, RID} !== 20'h0) begin
      errors++; $display("FAIL reset_resp: got rdata %h fields %h expected 0", RDATA, {BRESP, RRESP, BID, RID});
    end
    @(negedge ACLK);
    ARESET = 1'b0; mem_clr = 1'b0; AWVALID = 1'b0; ARVALID = 1'b0;
  endtask

  task automatic test_single_write;
    bit ok; logic [13:0] a; logic [3:0] web; logic cs; logic [31:0] di; logic [7:0] id; logic [1:0] resp;
    aw_send(8'h5A, 32'h10, 4'd0, 2'b01, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sw_aw: got no AWREADY expected handshake"); end
    w_send(32'hDEADBEEF, 4'b0011, 1'b1, ok, a, web, cs, di);
    checks++;
    if (!ok || a !== 14'h4 || cs !== 1'b1) begin
      errors++; $display("FAIL sw_addr: got ok=%0d A=%h CS=%b expected 1/0004/1", ok, a, cs);
    end
    checks++;
    if (web !== 4'b1100 || di !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_web_di: got %b/%h expected 1100/deadbeef", web, di);
    end
    b_recv(ok, id, resp);
    checks++;
    if (!ok || id !== 8'h5A || resp !== 2'b00) begin
      errors++; $display("FAIL sw_bresp: got ok=%0d id=%h resp=%b expected 1/5a/00", ok, id, resp);
    end
    checks++;
    if (mem[4] !== 32'h0000BEEF) begin
      errors++; $display("FAIL sw_mem: got %h expected 0000beef", mem[4]);
    end
  endtask

  task automatic test_incr_read;
    bit ok, last, stable; logic [13:0] a; logic [3:0] web; logic cs; logic [31:0] di, d;
    logic [7:0] id; logic [1:0] resp;
    aw_send(8'h21, 32'h0, 4'd3, 2'b01, ok);
    for (int i = 0; i < 4; i++) w_send(32'hC0DE0000 | i, 4'hF, i == 3, ok, a, web, cs, di);
    b_recv(ok, id, resp);
    checks++;
    if (!ok || resp !== 2'b00) begin
      errors++; $display("FAIL rd_setup_bresp: got ok=%0d resp=%b expected 1/00", ok, resp);
    end
    ar_send(8'h33, 32'h0, 4'd3, 2'b01, ok);
    for (int i = 0; i < 4; i++) begin
      r_recv((i == 1) ? 3 : 0, ok, d, resp, last, id, stable);
      checks++;
      if (!ok || d !== (32'hC0DE0000 | i) || resp !== 2'b00 || id !== 8'h33) begin
        errors++; $display("FAIL rd_beat%0d: got ok=%0d data=%h resp=%b id=%h expected 1/%h/00/33",
                           i, ok, d, resp, id, 32'hC0DE0000 | i);
      end
      checks++;
      if (last !== (i == 3)) begin
        errors++; $display("FAIL rd_rlast%0d: got %b expected %b", i, last, i == 3);
      end
      if (i == 1) begin
        checks++;
        if (!stable) begin errors++; $display("FAIL rd_stall_stable: got changing RDATA expected %h held", d); end
      end
    end
  endtask

  task automatic test_arbitration;
    bit ok, last, stable; logic [13:0] a; logic [3:0] web; logic cs; logic [31:0] di, d;
    logic [7:0] id; logic [1:0] resp;
    @(negedge ACLK); ARESET = 1'b1;
    @(negedge ACLK); ARESET = 1'b0;
    AWID = 8'h01; AWADDR = 32'h20; AWLEN = 4'd0; AWBURST = 2'b01; AWSIZE = 3'd2; AWVALID = 1'b1;
    ARID = 8'h02; ARADDR = 32'h10; ARLEN = 4'd0; ARBURST = 2'b01; ARSIZE = 3'd2; ARVALID = 1'b1;
    #1;
    checks++;
    if ({AWREADY, ARREADY} !== 2'b10) begin
      errors++; $display("FAIL arb_first: got AW/AR ready %b expected 10", {AWREADY, ARREADY});
    end
    @(posedge ACLK); #1 AWVALID = 1'b0;
    w_send(32'h12345678, 4'hF, 1'b1, ok, a, web, cs, di);
    b_recv(ok, id, resp);
    checks++;
    if (!ok || id !== 8'h01) begin errors++; $display("FAIL arb_wr_bid: got ok=%0d id=%h expected 1/01", ok, id); end
    @(negedge ACLK);
    AWID = 8'h03; AWADDR = 32'h24; AWVALID = 1'b1;
    #1;
    checks++;
    if ({AWREADY, ARREADY} !== 2'b01) begin
      errors++; $display("FAIL arb_second: got AW/AR ready %b expected 01", {AWREADY, ARREADY});
    end
    @(posedge ACLK); #1 ARVALID = 1'b0;
    r_recv(0, ok, d, resp, last, id, stable);
    checks++;
    if (!ok || d !== 32'h0000BEEF || id !== 8'h02) begin
      errors++; $display("FAIL arb_rd: got ok=%0d data=%h id=%h expected 1/0000beef/02", ok, d, id);
    end
    @(negedge ACLK); #1;
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL arb_pending_aw: got AWREADY %b expected 1", AWREADY); end
    @(posedge ACLK); #1 AWVALID = 1'b0;
    w_send(32'h0BADF00D, 4'hF, 1'b1, ok, a, web, cs, di);
    b_recv(ok, id, resp);
    checks++;
    if (!ok || id !== 8'h03 || mem[9] !== 32'h0BADF00D) begin
      errors++; $display("FAIL arb_wr2: got ok=%0d id=%h mem=%h expected 1/03/0badf00d", ok, id, mem[9]);
    end
  endtask

  task automatic test_error_reads;
    bit ok, last, stable; logic [31:0] d; logic [7:0] id; logic [1:0] resp; int c0;
    c0 = cs_cnt;
    ar_send(8'h07, 32'h0001_0000, 4'd0, 2'b01, ok);
    r_recv(0, ok, d, resp, last, id, stable);
    checks++;
    if (!ok || resp !== 2'b11 || d !== 32'h0 || last !== 1'b1) begin
      errors++; $display("FAIL decerr_rd: got ok=%0d resp=%b data=%h last=%b expected 1/11/0/1", ok, resp, d, last);
    end
    for (int i = 0; i < 1; i++) ;
    ar_send(8'h08, 32'h0, 4'd1, 2'b11, ok);
    for (int i = 0; i < 2; i++) begin
      r_recv(0, ok, d, resp, last, id, stable);
      checks++;
      if (!ok || resp !== 2'b10 || d !== 32'h0 || last !== (i == 1)) begin
        errors++; $display("FAIL slverr_rd%0d: got ok=%0d resp=%b data=%h last=%b expected 1/10/0/%0d",
                           i, ok, resp, d, last, i == 1);
      end
    end
    checks++;
    if (cs_cnt !== c0) begin errors++; $display("FAIL err_no_cs: got %0d CS cycles expected 0", cs_cnt - c0); end
  endtask

  task automatic test_early_wlast_wrap;
    bit ok; logic [13:0] a; logic [3:0] web; logic cs; logic [31:0] di; logic [7:0] id; logic [1:0] resp; int w0;
    w0 = wr_cnt;
    aw_send(8'h09, 32'h0000_FFFC, 4'd3, 2'b01, ok);
    w_send(32'hA5A5A5A5, 4'hF, 1'b0, ok, a, web, cs, di);
    checks++;
    if (!ok || a !== 14'h3FFF) begin errors++; $display("FAIL wrap_top: got ok=%0d A=%h expected 1/3fff", ok, a); end
    w_send(32'h5A5A5A5A, 4'hF, 1'b1, ok, a, web, cs, di);
    checks++;
    if (!ok || a !== 14'h0000) begin errors++; $display("FAIL wrap_zero: got ok=%0d A=%h expected 1/0000", ok, a); end
    b_recv(ok, id, resp);
    checks++;
    if (!ok || resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp: got ok=%0d resp=%b expected 1/10", ok, resp); end
    checks++;
    if (wr_cnt - w0 !== 2 || mem[0] !== 32'h5A5A5A5A || mem[14'h3FFF] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL early_wlast_writes: got %0d writes mem0=%h mem3fff=%h expected 2/5a5a5a5a/a5a5a5a5",
                         wr_cnt - w0, mem[0], mem[14'h3FFF]);
    end
  endtask

  task automatic test_reset_mid_burst;
    bit ok, saw_b; logic [13:0] a; logic [3:0] web; logic cs; logic [31:0] di; logic [7:0] id; logic [1:0] resp; int w0;
    w0 = wr_cnt;
    aw_send(8'h0B, 32'h40, 4'd3, 2'b01, ok);
    w_send(32'h11111111, 4'hF, 1'b0, ok, a, web, cs, di);
    @(negedge ACLK);
    WDATA = 32'h22222222; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1; ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0; WVALID = 1'b0;
    checks++;
    if ({WREADY, BVALID, RVALID, CS, OE} !== 5'b0 || WEB !== 4'hF || RDATA !== 32'h0) begin
      errors++; $display("FAIL midrst_outputs: got %b web=%h rdata=%h expected 00000/f/0",
                         {WREADY, BVALID, RVALID, CS, OE}, WEB, RDATA);
    end
    BREADY = 1'b1; saw_b = 1'b0;
    repeat (4) begin @(negedge ACLK); #1; if (BVALID) saw_b = 1'b1; end
    BREADY = 1'b0;
    checks++;
    if (saw_b || wr_cnt - w0 !== 1 || mem[17] !== 32'h0) begin
      errors++; $display("FAIL midrst_abort: got bvalid=%b writes=%0d mem11=%h expected 0/1/0", saw_b, wr_cnt - w0, mem[17]);
    end
    aw_send(8'h0C, 32'h44, 4'd0, 2'b01, ok);
    w_send(32'hCAFEF00D, 4'hF, 1'b1, ok, a, web, cs, di);
    b_recv(ok, id, resp);
    checks++;
    if (!ok || id !== 8'h0C || resp !== 2'b00 || mem[17] !== 32'hCAFEF00D || mem[16] !== 32'h11111111) begin
      errors++; $display("FAIL midrst_recover: got ok=%0d id=%h resp=%b mem=%h/%h expected 1/0c/00/cafef00d/11111111",
                         ok, id, resp, mem[17], mem[16]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr_read();
    test_arbitration();
    test_error_reads();
    test_early_wlast_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
